// File: rtl/bsg_relay_fifo_pkg.sv
// Shared helpers and types for the ready/valid relay FIFO.
package bsg_relay_fifo_pkg;

    // Pointer width for an els-entry ring. A single entry still needs one bit.
    function automatic int ptr_width(input int els);
        return (els == 1) ? 1 : $clog2(els);
    endfunction

    // Counter width able to hold 0..els inclusive.
    function automatic int cnt_width(input int els);
        return $clog2(els + 1);
    endfunction

    // What the occupancy counter does this cycle.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-read one-write register file: registered write, asynchronous read.
// Contents are not reset.
module bsg_mem_1r1w #(
    parameter int width_p = 32,
    parameter int els_p = 2,
    parameter int read_write_same_addr_p = 0,
    localparam int addr_w_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
    input  logic                 w_clk_i,
    input  logic                 w_v_i,
    input  logic [addr_w_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]   w_data_i,
    input  logic                 r_v_i,
    input  logic [addr_w_lp-1:0] r_addr_i,
    output logic [width_p-1:0]   r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    // Write port.
    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

    // Reading and writing one address in the same cycle is undefined here,
    // so the owner must never do it.
    if (read_write_same_addr_p == 0) begin : g_no_rw_same
        always @(posedge w_clk_i) begin
            assert (!(w_v_i && r_v_i && (w_addr_i == r_addr_i)))
                else $error("bsg_mem_1r1w: same-address read and write");
        end
    end

endmodule

// File: rtl/bsg_relay_fifo_ptr.sv
// Modulo-els_p wrapping pointer with increment enable and async reset to 0.
// Wraps explicitly at els_p-1 so non-power-of-two depths work.
module bsg_relay_fifo_ptr
    import bsg_relay_fifo_pkg::*;
#(
    parameter int els_p = 2,
    localparam int ptr_w_lp = ptr_width(els_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                incr_i,
    output logic [ptr_w_lp-1:0] ptr_o
);

    localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);

    logic [ptr_w_lp-1:0] ptr_q, ptr_d;

    // Next pointer: hold, step, or wrap back to entry 0.
    always_comb begin
        ptr_d = ptr_q;
        if (incr_i) begin
            ptr_d = (ptr_q == last_lp) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/bsg_relay_fifo_n.sv
// Ready/valid relay FIFO. ready_o is a pure function of the registered full
// flag (and reset), so it never depends on ready_i and instances chain safely.
// Handshake: a word moves upstream when v_i & ready_o, and downstream when
// v_o & ready_i; v_o/data_o stay stable until that downstream transfer.
module bsg_relay_fifo_n
    import bsg_relay_fifo_pkg::*;
#(
    parameter int width_p = 32,
    parameter int els_p = 2,
    parameter int bypass_p = 0,
    parameter int afull_thresh_p = els_p - 1,
    localparam int ptr_w_lp = ptr_width(els_p),
    localparam int cnt_w_lp = cnt_width(els_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                v_i,
    input  logic [width_p-1:0]  data_i,
    output logic                ready_o,
    output logic                v_o,
    output logic [width_p-1:0]  data_o,
    input  logic                ready_i,
    output logic [cnt_w_lp-1:0] count_o,
    output logic                afull_o
);

    localparam logic                bypass_lp = (bypass_p != 0);
    localparam logic [cnt_w_lp-1:0] els_lp    = cnt_w_lp'(els_p);
    localparam logic [cnt_w_lp-1:0] thresh_lp = cnt_w_lp'(afull_thresh_p);

    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic [ptr_w_lp-1:0] wptr_lo, rptr_lo;
    logic [width_p-1:0]  mem_data_lo;
    logic                enq, deq, pass_thru, mem_w, mem_r;
    cnt_op_e             cnt_op;

    // Held low during reset even though the full flag is already clear.
    assign ready_o = ~full_q & ~reset_i;

    // Downstream view: storage head, or the upstream word when empty and bypassing.
    always_comb begin
        v_o    = ~empty_q & ~reset_i;
        data_o = mem_data_lo;
        if (bypass_lp && empty_q) begin
            v_o    = v_i & ~reset_i;
            data_o = data_i;
        end
    end

    assign enq       = v_i & ready_o;
    assign deq       = v_o & ready_i;
    // Empty bypass with the consumer ready: the word never touches storage.
    assign pass_thru = bypass_lp & empty_q & ready_i;
    assign mem_w     = enq & ~pass_thru;
    assign mem_r     = deq & ~empty_q;

    // Occupancy change: stored writes add, reads from storage subtract.
    always_comb begin
        cnt_op = CNT_HOLD;
        if (mem_w && !mem_r) begin
            cnt_op = CNT_INC;
        end else if (mem_r && !mem_w) begin
            cnt_op = CNT_DEC;
        end
    end

    // Next count and the flags derived from it.
    always_comb begin
        count_d = count_q;
        case (cnt_op)
            CNT_INC: count_d = count_q + 1'b1;
            CNT_DEC: count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == els_lp);
        empty_d = (count_d == '0);
    end

    // Registered flags and count.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign count_o = count_q;
    // From the count register, not next-state.
    assign afull_o = (count_q >= thresh_lp);

    bsg_relay_fifo_ptr #(.els_p(els_p)) u_wptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .incr_i  (mem_w),
        .ptr_o   (wptr_lo)
    );

    bsg_relay_fifo_ptr #(.els_p(els_p)) u_rptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .incr_i  (mem_r),
        .ptr_o   (rptr_lo)
    );

    bsg_mem_1r1w #(
        .width_p                (width_p),
        .els_p                  (els_p),
        .read_write_same_addr_p (0)
    ) u_mem (
        .w_clk_i  (clk_i),
        .w_v_i    (mem_w),
        .w_addr_i (wptr_lo),
        .w_data_i (data_i),
        .r_v_i    (mem_r),
        .r_addr_i (rptr_lo),
        .r_data_o (mem_data_lo)
    );

endmodule

// File: tb/tb_bsg_relay_fifo_n.sv
// Bench for bsg_relay_fifo_n. Five instances:
//   0: els 4, no bypass   1: els 3, no bypass   2: els 4, bypass
//   3: els 2, no bypass   4: els 5, no bypass
`timescale 1ns/1ps
module tb_bsg_relay_fifo_n;

    localparam int N = 5;
    localparam int ELS [N] = '{4, 3, 4, 2, 5};
    localparam int BYP [N] = '{0, 0, 1, 0, 0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst;
    logic [N-1:0] v_i, rdy_i;
    logic [N-1:0] v_o, rdy_o, afull;
    logic [31:0]  din  [N];
    logic [31:0]  dout [N];
    logic [2:0]   c0, c2, c4;
    logic [1:0]   c1, c3;
    logic [2:0]   cnt [N];

    assign cnt[0] = c0;
    assign cnt[1] = {1'b0, c1};
    assign cnt[2] = c2;
    assign cnt[3] = {1'b0, c3};
    assign cnt[4] = c4;

    bsg_relay_fifo_n #(.width_p(32), .els_p(4), .bypass_p(0)) d0 (
        .clk_i(clk), .reset_i(rst[0]), .v_i(v_i[0]), .data_i(din[0]), .ready_o(rdy_o[0]),
        .v_o(v_o[0]), .data_o(dout[0]), .ready_i(rdy_i[0]), .count_o(c0), .afull_o(afull[0]));
    bsg_relay_fifo_n #(.width_p(32), .els_p(3), .bypass_p(0)) d1 (
        .clk_i(clk), .reset_i(rst[1]), .v_i(v_i[1]), .data_i(din[1]), .ready_o(rdy_o[1]),
        .v_o(v_o[1]), .data_o(dout[1]), .ready_i(rdy_i[1]), .count_o(c1), .afull_o(afull[1]));
    bsg_relay_fifo_n #(.width_p(32), .els_p(4), .bypass_p(1)) d2 (
        .clk_i(clk), .reset_i(rst[2]), .v_i(v_i[2]), .data_i(din[2]), .ready_o(rdy_o[2]),
        .v_o(v_o[2]), .data_o(dout[2]), .ready_i(rdy_i[2]), .count_o(c2), .afull_o(afull[2]));
    bsg_relay_fifo_n #(.width_p(32), .els_p(2), .bypass_p(0)) d3 (
        .clk_i(clk), .reset_i(rst[3]), .v_i(v_i[3]), .data_i(din[3]), .ready_o(rdy_o[3]),
        .v_o(v_o[3]), .data_o(dout[3]), .ready_i(rdy_i[3]), .count_o(c3), .afull_o(afull[3]));
    bsg_relay_fifo_n #(.width_p(32), .els_p(5), .bypass_p(0)) d4 (
        .clk_i(clk), .reset_i(rst[4]), .v_i(v_i[4]), .data_i(din[4]), .ready_o(rdy_o[4]),
        .v_o(v_o[4]), .data_o(dout[4]), .ready_i(rdy_i[4]), .count_o(c4), .afull_o(afull[4]));

    // ---------------- scoreboard state ----------------
    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q [N][$];
    logic        hold_v [N];
    logic [31:0] hold_d [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 100)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    // Queue-based reference: occupancy is the queue depth, output valid is
    // "queue non-empty, or bypassing an offered word", and every downstream
    // transfer pops and compares the oldest accepted word.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            int   sz;
            logic ev;
            logic [31:0] e;
            if (rst[k]) begin
                exp_q[k].delete();
                hold_v[k] = 1'b0;
            end else begin
                sz = exp_q[k].size();
                ev = (sz > 0) || ((BYP[k] != 0) && v_i[k]);
                chk($sformatf("d%0d v_o", k), {31'b0, v_o[k]}, {31'b0, ev});
                chk($sformatf("d%0d ready_o", k), {31'b0, rdy_o[k]}, {31'b0, sz < ELS[k]});
                chk($sformatf("d%0d count_o", k), {29'b0, cnt[k]}, 32'(sz));
                chk($sformatf("d%0d afull_o", k), {31'b0, afull[k]}, {31'b0, sz >= ELS[k] - 1});
                if (hold_v[k]) begin
                    chk($sformatf("d%0d hold_v", k), {31'b0, v_o[k]}, 32'd1);
                    chk($sformatf("d%0d hold_data", k), dout[k], hold_d[k]);
                end
                if (v_i[k] && sz < ELS[k]) exp_q[k].push_back(din[k]);
                if (v_o[k] && rdy_i[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("d%0d spurious_deq", k), 32'd1, 32'd0);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk($sformatf("d%0d data_o", k), dout[k], e);
                    end
                end
                hold_v[k] = v_o[k] && !rdy_i[k];
                hold_d[k] = dout[k];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic [31:0] d, input logic r);
        v_i[k]   = v;
        din[k]   = d;
        rdy_i[k] = r;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        for (int k = 0; k < N; k++) hold_v[k] = 1'b0;
        rst   = '1;
        v_i   = '0;
        rdy_i = '0;
        for (int k = 0; k < N; k++) din[k] = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready_o", {31'b0, rdy_o[0]}, 32'd0);
        chk("reset v_o", {31'b0, v_o[0]}, 32'd0);
        chk("reset count_o", {29'b0, cnt[0]}, 32'd0);
        chk("reset afull_o", {31'b0, afull[0]}, 32'd0);
        chk("reset byp v_o", {31'b0, v_o[2]}, 32'd0);
        cyc();
        rst = '0;
        @(negedge clk);
        chk("release ready_o", {31'b0, rdy_o[0]}, 32'd1);

        // 1: fill to full with downstream stalled, then one ignored push
        for (int i = 0; i < 5; i++) begin
            cyc();
            drive(0, 1'b1, 32'hA0 + 32'(i), 1'b0);
            @(negedge clk);
            chk("fill count_o", {29'b0, cnt[0]}, 32'(i));
            chk("fill ready_o", {31'b0, rdy_o[0]}, (i < 4) ? 32'd1 : 32'd0);
            chk("fill afull_o", {31'b0, afull[0]}, (i >= 3) ? 32'd1 : 32'd0);
        end
        cyc();
        drive(0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("full count_o", {29'b0, cnt[0]}, 32'd4);
        chk("full head", dout[0], 32'hA0);

        // 2: drain from full
        for (int j = 0; j < 4; j++) begin
            cyc();
            drive(0, 1'b0, 32'h0, 1'b1);
            @(negedge clk);
            chk("drain data_o", dout[0], 32'hA0 + 32'(j));
            chk("drain v_o", {31'b0, v_o[0]}, 32'd1);
            chk("drain ready_o", {31'b0, rdy_o[0]}, (j > 0) ? 32'd1 : 32'd0);
        end
        cyc();
        drive(0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("drained v_o", {31'b0, v_o[0]}, 32'd0);
        chk("drained count_o", {29'b0, cnt[0]}, 32'd0);

        // 3: streaming through els 4 and els 3
        for (int j = 0; j < 20; j++) begin
            cyc();
            drive(0, 1'b1, 32'(j), 1'b1);
            drive(1, 1'b1, 32'(j), 1'b1);
            @(negedge clk);
            chk("stream4 count_o", {29'b0, cnt[0]}, (j == 0) ? 32'd0 : 32'd1);
            chk("stream3 count_o", {29'b0, cnt[1]}, (j == 0) ? 32'd0 : 32'd1);
            if (j > 0) begin
                chk("stream4 data_o", dout[0], 32'(j - 1));
                chk("stream3 data_o", dout[1], 32'(j - 1));
            end
        end
        cyc();
        drive(0, 1'b0, 32'h0, 1'b1);
        drive(1, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("stream4 last", dout[0], 32'd19);
        chk("stream3 last", dout[1], 32'd19);
        cyc();
        drive(0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("stream4 idle v_o", {31'b0, v_o[0]}, 32'd0);
        chk("stream3 idle v_o", {31'b0, v_o[1]}, 32'd0);

        // 4: bypass pass-through, then a stalled word gets stored
        cyc();
        drive(2, 1'b1, 32'h55, 1'b1);
        @(negedge clk);
        chk("byp v_o", {31'b0, v_o[2]}, 32'd1);
        chk("byp data_o", dout[2], 32'h55);
        chk("byp count_o", {29'b0, cnt[2]}, 32'd0);
        cyc();
        drive(2, 1'b1, 32'h66, 1'b0);
        @(negedge clk);
        chk("byp2 data_o", dout[2], 32'h66);
        chk("byp2 count_o", {29'b0, cnt[2]}, 32'd0);
        cyc();
        drive(2, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("byp stored count_o", {29'b0, cnt[2]}, 32'd1);
        chk("byp stored v_o", {31'b0, v_o[2]}, 32'd1);
        chk("byp stored data_o", dout[2], 32'h66);
        cyc();
        drive(2, 1'b0, 32'h0, 1'b1);
        cyc();
        drive(2, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("byp empty v_o", {31'b0, v_o[2]}, 32'd0);

        // 5: random traffic on els 2, els 5 and the bypass instance
        for (int c = 0; c < 10000; c++) begin
            cyc();
            for (int k = 2; k < N; k++)
                drive(k, 1'(($urandom_range(0, 1))), $urandom, 1'(($urandom_range(0, 1))));
        end
        cyc();
        for (int k = 2; k < N; k++) drive(k, 1'b0, 32'h0, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        for (int k = 2; k < N; k++) chk($sformatf("d%0d drained", k), 32'(exp_q[k].size()), 32'd0);
        cyc();
        for (int k = 2; k < N; k++) drive(k, 1'b0, 32'h0, 1'b0);

        // 6: asynchronous reset with three words buffered
        for (int i = 0; i < 3; i++) begin
            cyc();
            drive(0, 1'b1, 32'hB0 + 32'(i), 1'b0);
        end
        cyc();
        drive(0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("pre-reset count_o", {29'b0, cnt[0]}, 32'd3);
        #2;
        rst[0] = 1'b1;
        #1;
        chk("async v_o", {31'b0, v_o[0]}, 32'd0);
        chk("async ready_o", {31'b0, rdy_o[0]}, 32'd0);
        chk("async count_o", {29'b0, cnt[0]}, 32'd0);
        chk("async afull_o", {31'b0, afull[0]}, 32'd0);
        @(negedge clk);
        #2;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("post-reset ready_o", {31'b0, rdy_o[0]}, 32'd1);
        chk("post-reset v_o", {31'b0, v_o[0]}, 32'd0);
        cyc();
        drive(0, 1'b0, 32'h0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("no stale v_o", {31'b0, v_o[0]}, 32'd0);
        end
        cyc();
        drive(0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
